// File: rtl/decode_64b67b_sync.sv
// decode_64b67b_sync
//   64B/67B receive block-sync decoder for an Interlaken lane. Finds the
//   word boundary by sliding a W-bit window across two consecutive input
//   words, locks after LOCK_CNT consecutive legal sync headers, drops lock
//   when ERR_MAX bad headers land inside one ERR_WIN-word window, strips the
//   inversion bit and keeps a saturating bad-header statistic.
//
// Ports
//   USER_CLK        in   sole clock, rising edge
//   SYSTEM_RESET_N  in   asynchronous active-low reset
//   PASSTHROUGH     in   holds the sync FSM in its reset condition
//   DATA_IN         in   W-bit raw gearbox word, bit W-1 received first
//   DATA_IN_VALID   in   qualifies DATA_IN
//   DATA_OUT        out  payload with the inversion bit removed
//   HEADER_OUT      out  aligned sync header
//   DATA_OUT_VALID  out  DATA_OUT/HEADER_OUT carry a new locked word
//   HDR_ERR         out  one-cycle pulse for an illegal header (00/11)
//   LOCKED          out  word lock achieved
//   CANDIDATE       out  current bit-slip offset
//   ERR_COUNT       out  saturating count of bad headers while locked
//   ERR_COUNT_CLR   in   synchronous clear of ERR_COUNT
`timescale 1ns/1ps
module decode_64b67b_sync #(
   parameter int DATA_W    = 64,
   parameter int LOCK_CNT  = 64,
   parameter int ERR_WIN   = 64,
   parameter int ERR_MAX   = 16,
   parameter int ERR_CNT_W = 16
) (
   input  logic                         USER_CLK,
   input  logic                         SYSTEM_RESET_N,
   input  logic                         PASSTHROUGH,
   input  logic [DATA_W+2:0]            DATA_IN,
   input  logic                         DATA_IN_VALID,
   output logic [DATA_W-1:0]            DATA_OUT,
   output logic [1:0]                   HEADER_OUT,
   output logic                         DATA_OUT_VALID,
   output logic                         HDR_ERR,
   output logic                         LOCKED,
   output logic [$clog2(DATA_W+3)-1:0]  CANDIDATE,
   output logic [ERR_CNT_W-1:0]         ERR_COUNT,
   input  logic                         ERR_COUNT_CLR
);

   localparam int W  = DATA_W + 3;
   localparam int CW = $clog2(W);
   localparam int GW = $clog2(LOCK_CNT);
   localparam int WW = $clog2(ERR_WIN);
   localparam int EW = $clog2(ERR_MAX + 1);

   localparam logic [CW-1:0] CAND_LAST = CW'(W - 1);
   localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
   localparam logic [WW-1:0] WIN_LAST  = WW'(ERR_WIN - 1);
   localparam logic [EW-1:0] ERR_LIMIT = EW'(ERR_MAX);

   localparam logic [0:0] ST_SYNCING = 1'b0;
   localparam logic [0:0] ST_LOCKED  = 1'b1;

   logic [W-1:0]   rx_r;
   logic [2*W-1:0] common;
   logic           v1;
   logic [0:0]     state;
   logic [GW-1:0]  good_ctr;
   logic [WW-1:0]  win_ctr;
   logic [EW-1:0]  err_ctr;

   logic [W-1:0]   aligned;
   logic           hdr_bad;
   logic [CW-1:0]  cand_next;
   logic [EW-1:0]  err_next;
   logic           cnt_inc;

   assign LOCKED = (state == ST_LOCKED);

   // Older word sits in the upper half of common, so a larger offset reaches
   // further back into the previous word.
   always_comb begin
      aligned   = common[CANDIDATE +: W];
      hdr_bad   = (aligned[W-2] == aligned[W-3]);
      cand_next = (CANDIDATE == CAND_LAST) ? '0 : CANDIDATE + CW'(1);
      err_next  = err_ctr + EW'(hdr_bad);
      cnt_inc   = v1 & LOCKED & hdr_bad;
   end

   // Stage 1: two-word capture
   always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
      if (!SYSTEM_RESET_N) begin
         rx_r   <= '0;
         common <= '0;
         v1     <= 1'b0;
      end else begin
         v1 <= DATA_IN_VALID;
         if (DATA_IN_VALID) begin
            rx_r   <= DATA_IN;
            common <= {rx_r, DATA_IN};
         end
      end
   end

   // Stage 2: aligned word output
   always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
      if (!SYSTEM_RESET_N) begin
         DATA_OUT       <= '0;
         HEADER_OUT     <= '0;
         HDR_ERR        <= 1'b0;
         DATA_OUT_VALID <= 1'b0;
      end else begin
         DATA_OUT_VALID <= v1 & LOCKED;
         if (v1) begin
            HEADER_OUT <= aligned[W-2:W-3];
            DATA_OUT   <= aligned[DATA_W-1:0] ^ {DATA_W{aligned[W-1]}};
            HDR_ERR    <= hdr_bad;
         end else begin
            HDR_ERR    <= 1'b0;
         end
      end
   end

   // Sync FSM
   always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
      if (!SYSTEM_RESET_N) begin
         state     <= ST_SYNCING;
         CANDIDATE <= '0;
         good_ctr  <= '0;
         win_ctr   <= '0;
         err_ctr   <= '0;
      end else if (PASSTHROUGH) begin
         state     <= ST_SYNCING;
         CANDIDATE <= '0;
         good_ctr  <= '0;
         win_ctr   <= '0;
         err_ctr   <= '0;
      end else if (v1) begin
         if (state == ST_SYNCING) begin
            if (!hdr_bad) begin
               if (good_ctr == GOOD_LAST) begin
                  state    <= ST_LOCKED;
                  good_ctr <= '0;
                  win_ctr  <= '0;
                  err_ctr  <= '0;
               end else begin
                  good_ctr <= good_ctr + GW'(1);
               end
            end else begin
               good_ctr  <= '0;
               CANDIDATE <= cand_next;
            end
         end else begin
            // Loss of lock wins over the window wrap on the same word.
            if (hdr_bad && (err_next == ERR_LIMIT)) begin
               state     <= ST_SYNCING;
               CANDIDATE <= cand_next;
               good_ctr  <= '0;
               win_ctr   <= '0;
               err_ctr   <= '0;
            end else if (win_ctr == WIN_LAST) begin
               win_ctr <= '0;
               err_ctr <= '0;
            end else begin
               win_ctr <= win_ctr + WW'(1);
               err_ctr <= err_next;
            end
         end
      end
   end

   // Bad-header statistic; a clear coinciding with an error leaves 1.
   always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
      if (!SYSTEM_RESET_N) begin
         ERR_COUNT <= '0;
      end else if (ERR_COUNT_CLR) begin
         ERR_COUNT <= cnt_inc ? ERR_CNT_W'(1) : '0;
      end else if (cnt_inc && !(&ERR_COUNT)) begin
         ERR_COUNT <= ERR_COUNT + ERR_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_decode_64b67b_sync.sv
// tb_decode_64b67b_sync
//   Scoreboard bench for decode_64b67b_sync. Blocks are serialised into a
//   bit stream, cut into W-bit words at a chosen boundary offset and driven
//   into two instances (default and 4-bit statistics counter). A reference
//   model pushes each expected delivered word into a queue; a monitor pops
//   and compares whenever DATA_OUT_VALID is seen.
`timescale 1ns/1ps
module tb_decode_64b67b_sync;

   localparam int DW = 64;
   localparam int W  = DW + 3;
   localparam int CW = $clog2(W);
   localparam int LOCK = 64;
   localparam int WIN  = 64;
   localparam int EMAX = 16;

   logic          USER_CLK = 1'b0;
   logic          SYSTEM_RESET_N;
   logic          PASSTHROUGH;
   logic [W-1:0]  DATA_IN;
   logic          DATA_IN_VALID;
   logic          ERR_COUNT_CLR;
   logic [DW-1:0] DATA_OUT;
   logic [1:0]    HEADER_OUT;
   logic          DATA_OUT_VALID;
   logic          HDR_ERR;
   logic          LOCKED;
   logic [CW-1:0] CANDIDATE;
   logic [15:0]   ERR_COUNT;

   logic [DW-1:0] d4_data;
   logic [1:0]    d4_hdr;
   logic          d4_valid;
   logic          d4_hdr_err;
   logic          d4_locked;
   logic [CW-1:0] d4_cand;
   logic [3:0]    d4_err_count;

   decode_64b67b_sync #(.DATA_W(DW), .LOCK_CNT(LOCK), .ERR_WIN(WIN),
                        .ERR_MAX(EMAX), .ERR_CNT_W(16)) u_dut (
      .USER_CLK(USER_CLK), .SYSTEM_RESET_N(SYSTEM_RESET_N),
      .PASSTHROUGH(PASSTHROUGH), .DATA_IN(DATA_IN),
      .DATA_IN_VALID(DATA_IN_VALID), .DATA_OUT(DATA_OUT),
      .HEADER_OUT(HEADER_OUT), .DATA_OUT_VALID(DATA_OUT_VALID),
      .HDR_ERR(HDR_ERR), .LOCKED(LOCKED), .CANDIDATE(CANDIDATE),
      .ERR_COUNT(ERR_COUNT), .ERR_COUNT_CLR(ERR_COUNT_CLR));

   decode_64b67b_sync #(.DATA_W(DW), .LOCK_CNT(LOCK), .ERR_WIN(WIN),
                        .ERR_MAX(EMAX), .ERR_CNT_W(4)) u_dut4 (
      .USER_CLK(USER_CLK), .SYSTEM_RESET_N(SYSTEM_RESET_N),
      .PASSTHROUGH(PASSTHROUGH), .DATA_IN(DATA_IN),
      .DATA_IN_VALID(DATA_IN_VALID), .DATA_OUT(d4_data),
      .HEADER_OUT(d4_hdr), .DATA_OUT_VALID(d4_valid),
      .HDR_ERR(d4_hdr_err), .LOCKED(d4_locked), .CANDIDATE(d4_cand),
      .ERR_COUNT(d4_err_count), .ERR_COUNT_CLR(ERR_COUNT_CLR));

   always #5 USER_CLK = ~USER_CLK;

   int unsigned edge_no = 0;
   always @(posedge USER_CLK) edge_no <= edge_no + 1;

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    hdr;
      logic          err;
      int unsigned   due;
   } exp_t;

   exp_t expq[$];
   int   tests = 0;
   int   fails = 0;

   // reference model state
   logic [W-1:0] m_prev;
   bit           m_locked;
   int           m_cand, m_good, m_win, m_err, m_cnt, m_cnt4;

   // stream generator state
   bit sq[$];
   int disc;
   bit gap_mode = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset_fsm();
      m_locked = 0; m_cand = 0; m_good = 0; m_win = 0; m_err = 0;
   endtask

   // Decode one accepted word by the block-sync rules.
   task automatic model_word(input logic [W-1:0] w, input bit clr, input int unsigned due);
      logic [2*W-1:0] cat;
      logic [W-1:0]   al;
      bit             bad;
      exp_t           e;
      cat = {m_prev, w} >> m_cand;
      al  = cat[W-1:0];
      m_prev = w;
      bad = (al[W-2] == al[W-3]);
      if (m_locked) begin
         e.data = al[DW-1:0] ^ {DW{al[W-1]}};
         e.hdr  = al[W-2:W-3];
         e.err  = bad;
         e.due  = due;
         expq.push_back(e);
      end
      if (clr) begin
         m_cnt  = (m_locked && bad) ? 1 : 0;
         m_cnt4 = m_cnt;
      end else if (m_locked && bad) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt4 < 15) m_cnt4++;
      end
      if (!m_locked) begin
         if (!bad) begin
            m_good++;
            if (m_good == LOCK) begin
               m_locked = 1; m_good = 0; m_win = 0; m_err = 0;
            end
         end else begin
            m_good = 0;
            m_cand = (m_cand + 1) % W;
         end
      end else begin
         m_win++;
         if (bad) m_err++;
         if (bad && m_err == EMAX) begin
            m_locked = 0; m_cand = (m_cand + 1) % W;
            m_good = 0; m_win = 0; m_err = 0;
         end else if (m_win == WIN) begin
            m_win = 0; m_err = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge USER_CLK);
      #1;
   endtask

   task automatic idle(input int n);
      DATA_IN_VALID = 1'b0;
      repeat (n) tick();
   endtask

   task automatic emit(input logic [W-1:0] w, input bit clr_next);
      int n;
      DATA_IN = w;
      DATA_IN_VALID = 1'b1;
      model_word(w, clr_next, edge_no + 2);
      tick();
      if (clr_next) begin
         DATA_IN_VALID = 1'b0;
         ERR_COUNT_CLR = 1'b1;
         tick();
         ERR_COUNT_CLR = 1'b0;
      end else if (gap_mode) begin
         n = $urandom_range(0, 2);
         if (n > 0) idle(n);
      end
   endtask

   task automatic start_stream(input int o);
      sq.delete();
      disc = o;
   endtask

   task automatic push_block(input bit inv, input logic [1:0] hdr,
                             input logic [DW-1:0] pl, input bit clr_next);
      logic [W-1:0] b;
      logic [W-1:0] w;
      b = {inv, hdr, pl};
      for (int i = W - 1; i >= 0; i--) sq.push_back(b[i]);
      while (disc > 0) begin
         void'(sq.pop_front());
         disc--;
      end
      if (sq.size() >= W) begin
         for (int i = W - 1; i >= 0; i--) w[i] = sq.pop_front();
         emit(w, clr_next);
      end
   endtask

   task automatic push_hdr(input logic [1:0] hdr);
      push_block(1'($urandom_range(0, 1)), hdr, {$urandom, $urandom}, 1'b0);
   endtask

   task automatic push_legal();
      push_hdr(2'($urandom_range(1, 2)));
   endtask

   task automatic sync_up(input string name, input int bound);
      int n = 0;
      while (!m_locked && n < bound) begin
         push_legal();
         n++;
      end
      tests++;
      if (!m_locked) begin
         fails++;
         $display("FAIL %s: no lock within %0d words, expected lock", name, bound);
      end
   endtask

   task automatic check_state(input string name);
      idle(3);
      chk({name, "_locked"}, 64'(LOCKED), 64'(m_locked));
      chk({name, "_cand"}, 64'(CANDIDATE), 64'(m_cand));
      chk({name, "_errcnt"}, 64'(ERR_COUNT), 64'(m_cnt));
      chk({name, "_errcnt4"}, 64'(d4_err_count), 64'(m_cnt4));
   endtask

   task automatic passthrough();
      idle(2);
      PASSTHROUGH = 1'b1;
      tick();
      PASSTHROUGH = 1'b0;
      model_reset_fsm();
   endtask

   task automatic clr_pulse();
      idle(2);
      ERR_COUNT_CLR = 1'b1;
      tick();
      ERR_COUNT_CLR = 1'b0;
      m_cnt = 0; m_cnt4 = 0;
   endtask

   task automatic check_zero(input string name);
      chk({name, "_dout"}, 64'(DATA_OUT), 64'd0);
      chk({name, "_hdr"}, 64'(HEADER_OUT), 64'd0);
      chk({name, "_valid"}, 64'(DATA_OUT_VALID), 64'd0);
      chk({name, "_hdrerr"}, 64'(HDR_ERR), 64'd0);
      chk({name, "_locked"}, 64'(LOCKED), 64'd0);
      chk({name, "_cand"}, 64'(CANDIDATE), 64'd0);
      chk({name, "_errcnt"}, 64'(ERR_COUNT), 64'd0);
   endtask

   task automatic model_reset_all();
      model_reset_fsm();
      m_prev = '0; m_cnt = 0; m_cnt4 = 0;
      expq.delete();
   endtask

   // Scoreboard monitor
   always @(negedge USER_CLK) begin
      exp_t e;
      if (SYSTEM_RESET_N === 1'b1) begin
         if (DATA_OUT_VALID === 1'b1) begin
            tests++;
            if (expq.size() == 0) begin
               fails++;
               $display("FAIL out_unexpected: got data %h hdr %b, expected no word", DATA_OUT, HEADER_OUT);
            end else begin
               e = expq.pop_front();
               if (DATA_OUT !== e.data || HEADER_OUT !== e.hdr || HDR_ERR !== e.err || edge_no != e.due) begin
                  fails++;
                  $display("FAIL out_word: got data %h hdr %b err %b edge %0d, expected data %h hdr %b err %b edge %0d",
                           DATA_OUT, HEADER_OUT, HDR_ERR, edge_no, e.data, e.hdr, e.err, e.due);
               end
            end
         end else if (expq.size() > 0 && edge_no >= expq[0].due) begin
            tests++;
            fails++;
            $display("FAIL out_missing: got no valid at edge %0d, expected data %h", edge_no, expq[0].data);
            void'(expq.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      SYSTEM_RESET_N = 1'b0;
      PASSTHROUGH    = 1'b0;
      DATA_IN        = '0;
      DATA_IN_VALID  = 1'b0;
      ERR_COUNT_CLR  = 1'b0;
      model_reset_all();
      repeat (3) @(posedge USER_CLK);
      #1;
      check_zero("rst");
      chk("rst_errcnt4", 64'(d4_err_count), 64'd0);
      @(negedge USER_CLK);
      SYSTEM_RESET_N = 1'b1;

      // aligned stream: lock after exactly 64 valid words
      start_stream(0);
      repeat (LOCK - 1) push_legal();
      idle(3);
      chk("s1_pre_lock", 64'(LOCKED), 64'd0);
      check_state("s1a");
      push_legal();
      idle(3);
      chk("s1_lock", 64'(LOCKED), 64'd1);
      repeat (20) push_legal();
      check_state("s1b");

      // boundary 17 bits into the two-word window
      passthrough();
      start_stream(17);
      sync_up("s2_sync", 600);
      idle(3);
      chk("s2_cand", 64'(CANDIDATE), 64'd17);
      chk("s2_locked", 64'(LOCKED), 64'd1);
      repeat (10) push_legal();
      check_state("s2");

      // boundary at W-1, then error-window behaviour and candidate wrap
      passthrough();
      start_stream(W - 1);
      sync_up("s3_sync", 1500);
      idle(3);
      chk("s3_cand", 64'(CANDIDATE), 64'(W - 1));
      clr_pulse();
      // one legal block is already pending as window position 0
      for (int p = 1; p <= 128; p++)
         if ((p >= 1 && p <= 15) || (p >= 65 && p <= 79)) push_hdr(2'($urandom_range(0, 1) * 3));
         else push_legal();
      idle(3);
      chk("s3_mid_locked", 64'(LOCKED), 64'd1);
      chk("s3_mid_errcnt", 64'(ERR_COUNT), 64'd30);
      check_state("s3_mid");
      for (int p = 129; p <= 145; p++)
         if (p <= 144) push_hdr(2'($urandom_range(0, 1) * 3));
         else push_legal();
      idle(3);
      chk("s3_unlock", 64'(LOCKED), 64'd0);
      chk("s3_wrap", 64'(CANDIDATE), 64'd0);
      chk("s3_errcnt", 64'(ERR_COUNT), 64'd46);
      chk("s3_errcnt4_sat", 64'(d4_err_count), 64'd15);
      check_state("s3_end");

      // inversion bit, bad header pulse, clear coinciding with an error
      passthrough();
      start_stream(0);
      gap_mode = 1;
      sync_up("s4_sync", 200);
      push_block(1'b1, 2'b10, 64'h0123456789ABCDEF, 1'b0);
      push_block(1'b0, 2'b10, 64'h0123456789ABCDEF, 1'b0);
      push_hdr(2'b11);
      push_block(1'b1, 2'b00, {$urandom, $urandom}, 1'b1);
      idle(3);
      chk("s4_clr_errcnt", 64'(ERR_COUNT), 64'd1);
      chk("s4_clr_errcnt4", 64'(d4_err_count), 64'd1);
      check_state("s4a");
      repeat (40)
         if ($urandom_range(0, 7) == 0) push_hdr(2'($urandom_range(0, 1) * 3));
         else push_legal();
      check_state("s4b");
      gap_mode = 0;

      // reset mid-stream, then reacquire with gapped valid
      repeat (5) push_legal();
      DATA_IN_VALID = 1'b0;
      @(posedge USER_CLK);
      #2;
      SYSTEM_RESET_N = 1'b0;
      #1;
      check_zero("s5_rst");
      model_reset_all();
      repeat (2) @(posedge USER_CLK);
      @(negedge USER_CLK);
      SYSTEM_RESET_N = 1'b1;
      start_stream(0);
      gap_mode = 1;
      repeat (LOCK - 1) push_legal();
      idle(3);
      chk("s5_pre_lock", 64'(LOCKED), 64'd0);
      push_legal();
      idle(3);
      chk("s5_lock", 64'(LOCKED), 64'd1);
      repeat (10) push_legal();
      check_state("s5");
      gap_mode = 0;
      idle(4);
      chk("queue_drained", 64'(expq.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
